multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Control sequencer turning the single-cycle RV32I datapath into a multicycle one behind handshaked memories.
//  Holds FSM FETCH->DECODE->EXEC->[MEM->[WB]] and drives register enables, the PC mux and the writeback/operand muxes.
//  Decodes opcode/funct3 from the instruction register, so its opcode set matches the immediate generator's.
//  Detects illegal opcode, misaligned load/store and memory timeout, and parks in TRAP.
// PARAMETERS
//  MEM_TIMEOUT  16  cycles a req may wait for ack before trap; legal range 2..255
//  CNT_W        32  width of the instret counter
// PORTS
//  clk          in   1      sole clock, rising edge
//  rstn         in   1      synchronous active-low reset
//  instr        in   32     instruction register contents (valid from DECODE on)
//  br_taken     in   1      branch compare result from ALU, sampled in EXEC
//  dmem_addr_lo in   2      ALU address bits [1:0], sampled in EXEC
//  imem_req     out  1      instruction fetch request
//  imem_ack     in   1      fetch data valid this cycle
//  dmem_req     out  1      data memory request
//  dmem_we      out  1      1=store, 0=load; valid only with dmem_req
//  dmem_be      out  4      byte enables from funct3 and dmem_addr_lo
//  dmem_ack     in   1      data access complete this cycle
//  ir_we        out  1      load the instruction register
//  pc_we        out  1      update the PC
//  pc_sel       out  2      00 pc+4, 01 pc+imm, 10 alu_out&~1 (JALR)
//  alu_a_sel    out  1      0 rs1, 1 pc
//  alu_b_sel    out  1      0 rs2, 1 imm
//  rf_we        out  1      register file write enable
//  wb_sel       out  2      00 alu, 01 load data, 10 pc+4, 11 imm (LUI)
//  trap         out  1      sticky; high in TRAP
//  trap_cause   out  2      01 mem timeout, 10 illegal opcode, 11 misaligned
//  instret      out  CNT_W  retired-instruction count
// BEHAVIOUR
//  Reset (rstn=0 at edge): state=FETCH; instret=0; trap=0; trap_cause=0; timer=0. Reset wins over everything.
//  All strobes (ir_we, pc_we, rf_we, imem_req, dmem_req) are combinational from state+inputs; 0 outside their states.
//  FETCH: imem_req=1. When imem_ack=1: ir_we=1 and go to DECODE. Otherwise timer+1; timer==MEM_TIMEOUT-1 -> TRAP, cause 01.
//  DECODE: opcode outside {LUI,AUIPC,JAL,JALR,BXX,LXX,SXX,IXX,RXX} -> TRAP, cause 10. Otherwise go to EXEC. Timer cleared.
//  EXEC: alu_a_sel=1 for AUIPC/JAL/BXX, else 0. alu_b_sel=0 for RXX/BXX, else 1.
//   - RXX/IXX/LUI/AUIPC: rf_we=1, pc_we=1, pc_sel=00; retire; go to FETCH.
//   - JAL: rf_we=1, wb_sel=10, pc_sel=01. JALR: rf_we=1, wb_sel=10, pc_sel=10. Both retire and go to FETCH.
//   - BXX: pc_we=1, pc_sel = br_taken ? 01 : 00; rf_we=0; retire; go to FETCH.
//   - LXX/SXX: misaligned (half with addr_lo[0]=1, word with addr_lo!=0) -> TRAP, cause 11. Otherwise go to MEM.
//  MEM: dmem_req=1, dmem_we=(SXX). dmem_be: byte 0001<<lo, half 0011<<lo, word 1111.
//   - dmem_be for loads is identical to stores.
//   - On dmem_ack: SXX -> pc_we=1, pc_sel=00, retire, go to FETCH; LXX -> go to WB.
//   - Timeout handled exactly as in FETCH.
//  WB: rf_we=1, wb_sel=01, pc_we=1, pc_sel=00; retire; go to FETCH. Load data is registered by the datapath on the ack edge.
//  Retire: instret wraps modulo 2^CNT_W. The PC update and the retire happen in the same cycle.
//  Latency with zero-wait ack: ALU/branch/jump 3 cycles, store 4, load 5.
//  TRAP: all strobes 0. trap=1 and trap_cause hold until reset; instret frozen.
//  ack while req=0 is ignored. A single ack completes exactly one request. Timer resets on every state change.
// STRUCTURE
//  cpu_pkg holds the opcode constants (shared with immGen), the state encoding, the pc_sel/wb_sel encodings and the trap cause codes.
//  One sub-module: mem_wait_timer (clear, count-enable, expired flag at MEM_TIMEOUT-1). Used for both FETCH and MEM waits.
// TESTING
//  addi x1,x0,5 with immediate acks -> ir_we@c0, rf_we+pc_we(sel 00)@c2, instret=1 after 3 cycles.
//  lw with addr_lo=00, dmem_ack delayed 3 cycles -> dmem_be=1111, WB asserts rf_we, wb_sel=01; 8 cycles total.
//  sh with addr_lo=01 -> TRAP, cause 11; dmem_req never asserted; instret unchanged.
//  beq, br_taken=1 then 0 -> pc_sel=01, then 00; rf_we stays 0 in both cases.
//  imem_ack held low -> TRAP, cause 01, exactly MEM_TIMEOUT cycles after FETCH entry.
//  Opcode 7'b1111111 -> TRAP, cause 10. rstn low mid-MEM -> next cycle state=FETCH, dmem_req=0, trap=0, instret=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode constants, controller state encoding, mux select and trap cause codes
package cpu_pkg;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BXX   = 7'b1100011;
  localparam logic [6:0] OP_LXX   = 7'b0000011;
  localparam logic [6:0] OP_SXX   = 7'b0100011;
  localparam logic [6:0] OP_IXX   = 7'b0010011;
  localparam logic [6:0] OP_RXX   = 7'b0110011;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  localparam logic [1:0] PC_4 = 2'b00, PC_IMM = 2'b01, PC_ALU = 2'b10;
  localparam logic [1:0] WB_ALU = 2'b00, WB_LOAD = 2'b01, WB_PC4 = 2'b10, WB_IMM = 2'b11;
  localparam logic [1:0] TC_NONE = 2'b00, TC_TIMEOUT = 2'b01, TC_ILLEGAL = 2'b10, TC_MISALIGN = 2'b11;
  // size is funct3[1:0]: 00 byte, 01 half, 1x word
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    return size[1] ? 4'b1111 : size[0] ? 4'b0011 << lo : 4'b0001 << lo;
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts cycles a memory request waits for ack, flags the last allowed cycle
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  logic [7:0] count;
  always_ff @(posedge clk)
    if (!rstn || clear) count <= '0;
    else if (count_en) count <= count + 8'd1;
  assign expired = count == 8'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for a multicycle RV32I datapath with traps
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [31:0]      instr,
  input  logic             br_taken,
  input  logic [1:0]       dmem_addr_lo,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [3:0]       dmem_be,
  input  logic             dmem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);
  state_t state, next;
  logic [1:0] cause_next, lo_q, size;
  logic [6:0] op;
  logic legal, is_mem, misaligned, expired, retire, unused;
  assign op = instr[6:0];
  assign size = instr[13:12];
  assign unused = ^{instr[31:14], instr[11:7]};
  assign legal = op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BXX, OP_LXX, OP_SXX, OP_IXX, OP_RXX};
  assign is_mem = op == OP_LXX || op == OP_SXX;
  assign misaligned = (size == 2'b01 && dmem_addr_lo[0]) || (size[1] && |dmem_addr_lo);
  assign trap = state == S_TRAP;
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk(clk),
    .rstn(rstn),
    .clear(next != state),
    .count_en((state == S_FETCH && !imem_ack) || (state == S_MEM && !dmem_ack)),
    .expired(expired)
  );
  always_ff @(posedge clk)
    if (!rstn) begin
      state <= S_FETCH;
      trap_cause <= TC_NONE;
      instret <= '0;
      lo_q <= '0;
    end else begin
      state <= next;
      trap_cause <= cause_next;
      if (retire) instret <= instret + CNT_W'(1);
      if (state == S_EXEC) lo_q <= dmem_addr_lo;
    end
  always_comb begin
    next = state;
    cause_next = trap_cause;
    imem_req = 1'b0;
    ir_we = 1'b0;
    dmem_req = 1'b0;
    dmem_we = 1'b0;
    dmem_be = 4'b0000;
    pc_we = 1'b0;
    pc_sel = PC_4;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    rf_we = 1'b0;
    wb_sel = WB_ALU;
    retire = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we = imem_ack;
        if (imem_ack) next = S_DECODE;
        else if (expired) begin
          next = S_TRAP;
          cause_next = TC_TIMEOUT;
        end
      end
      S_DECODE: begin
        next = legal ? S_EXEC : S_TRAP;
        cause_next = legal ? trap_cause : TC_ILLEGAL;
      end
      S_EXEC: begin
        alu_a_sel = op == OP_AUIPC || op == OP_JAL || op == OP_BXX;
        alu_b_sel = !(op == OP_RXX || op == OP_BXX);
        if (is_mem) begin
          next = misaligned ? S_TRAP : S_MEM;
          cause_next = misaligned ? TC_MISALIGN : trap_cause;
        end else begin
          next = S_FETCH;
          retire = 1'b1;
          pc_we = 1'b1;
          rf_we = op != OP_BXX;
          wb_sel = (op == OP_JAL || op == OP_JALR) ? WB_PC4 : op == OP_LUI ? WB_IMM : WB_ALU;
          pc_sel = (op == OP_JAL || (op == OP_BXX && br_taken)) ? PC_IMM : op == OP_JALR ? PC_ALU : PC_4;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we = op == OP_SXX;
        dmem_be = byte_en(size, lo_q);
        if (dmem_ack) begin
          next = dmem_we ? S_FETCH : S_WB;
          pc_we = dmem_we;
          retire = dmem_we;
        end else if (expired) begin
          next = S_TRAP;
          cause_next = TC_TIMEOUT;
        end
      end
      S_WB: begin
        next = S_FETCH;
        rf_we = 1'b1;
        wb_sel = WB_LOAD;
        pc_we = 1'b1;
        retire = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: per-instruction cycle traces built from the ISA-level rules, checked every cycle
module tb_multicycle_ctrl;
  localparam int MT = 16;
  localparam int CW = 4;
  logic clk = 1'b0, rstn = 1'b0, br_taken = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic [31:0] instr = '0;
  logic [1:0] dmem_addr_lo = '0;
  logic imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_a_sel, alu_b_sel, rf_we, trap;
  logic [3:0] dmem_be;
  logic [1:0] pc_sel, wb_sel, trap_cause;
  logic [CW-1:0] instret;
  int compared = 0, mismatched = 0, cnt = 0, n;
  typedef struct {
    logic rstn, br, iack, dack, chk, alu_chk;
    logic [31:0] instr;
    logic [1:0] lo, pc_sel, wb_sel, cause;
    logic imem_req, ir_we, pc_we, rf_we, dmem_req, dmem_we, trap, alu_a, alu_b;
    logic [3:0] be;
    int instret;
  } ent_t;
  ent_t q[$];
  multicycle_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .instr(instr), .br_taken(br_taken), .dmem_addr_lo(dmem_addr_lo),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .rf_we(rf_we), .wb_sel(wb_sel),
    .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  function automatic ent_t blank(input logic [31:0] ins);
    ent_t e = '{default: '0};
    e.rstn = 1'b1;
    e.chk = 1'b1;
    e.instr = ins;
    e.instret = cnt % (1 << CW);
    return e;
  endfunction
  function automatic void push_reset();
    ent_t e = blank('0);
    e.rstn = 1'b0;
    e.chk = 1'b0;
    q.push_back(e);
    cnt = 0;
  endfunction
  function automatic void push_trap(input logic [1:0] c);
    ent_t e = blank('0);
    e.trap = 1'b1;
    e.cause = c;
    repeat (3) q.push_back(e);
  endfunction
  // Expected trace for one instruction: iw/dw are wait cycles before imem/dmem ack
  function automatic int gen(input logic [31:0] ins, input int iw, input int dw, input logic br,
                             input logic [1:0] lo, input int rst_mem = -1);
    ent_t e;
    int k = 0;
    logic [6:0] op = ins[6:0];
    logic [1:0] sz = ins[13:12];
    logic st = op == 7'b0100011;
    logic mem = st || op == 7'b0000011;
    logic word = sz >= 2'd2;
    logic mis = (sz == 2'd1 && lo[0]) || (word && lo != 0);
    for (int i = 0; i <= iw; i++) begin
      e = blank(ins);
      e.imem_req = 1'b1;
      if (i == iw) begin e.iack = 1'b1; e.ir_we = 1'b1; end
      q.push_back(e); k++;
      if (i == MT - 1 && i != iw) begin push_trap(2'b01); return k; end
    end
    q.push_back(blank(ins)); k++;
    if (!(op inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33})) begin
      push_trap(2'b10); return k;
    end
    e = blank(ins);
    e.br = br;
    e.lo = lo;
    e.alu_chk = 1'b1;
    e.alu_a = op inside {7'h17, 7'h6f, 7'h63};
    e.alu_b = !(op inside {7'h33, 7'h63});
    if (!mem) begin
      e.pc_we = 1'b1;
      e.rf_we = op != 7'h63;
      e.pc_sel = op == 7'h6f ? 2'd1 : op == 7'h67 ? 2'd2 : (op == 7'h63 && br) ? 2'd1 : 2'd0;
      e.wb_sel = op inside {7'h6f, 7'h67} ? 2'd2 : op == 7'h37 ? 2'd3 : 2'd0;
      q.push_back(e); cnt++; return k + 1;
    end
    q.push_back(e); k++;
    if (mis) begin push_trap(2'b11); return k; end
    for (int i = 0; i <= dw; i++) begin
      if (i == rst_mem) begin push_reset(); return k; end
      e = blank(ins);
      e.dmem_req = 1'b1;
      e.dmem_we = st;
      e.be = word ? 4'hF : (sz == 2'd1 ? 4'd3 : 4'd1) << lo;
      if (i == dw) begin e.dack = 1'b1; e.pc_we = st; end
      q.push_back(e); k++;
      if (i == MT - 1 && i != dw) begin push_trap(2'b01); return k; end
    end
    if (st) begin cnt++; return k; end
    e = blank(ins);
    e.rf_we = 1'b1;
    e.wb_sel = 2'd1;
    e.pc_we = 1'b1;
    q.push_back(e); cnt++;
    return k + 1;
  endfunction
  task automatic run();
    ent_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      rstn = e.rstn; instr = e.instr; br_taken = e.br; imem_ack = e.iack;
      dmem_ack = e.dack; dmem_addr_lo = e.lo;
      #2;
      if (e.chk) begin
        check("imem_req", int'(imem_req), int'(e.imem_req));
        check("ir_we", int'(ir_we), int'(e.ir_we));
        check("pc_we", int'(pc_we), int'(e.pc_we));
        check("rf_we", int'(rf_we), int'(e.rf_we));
        check("dmem_req", int'(dmem_req), int'(e.dmem_req));
        check("trap", int'(trap), int'(e.trap));
        check("trap_cause", int'(trap_cause), int'(e.cause));
        check("instret", int'(instret), e.instret);
        if (e.pc_we) check("pc_sel", int'(pc_sel), int'(e.pc_sel));
        if (e.rf_we) check("wb_sel", int'(wb_sel), int'(e.wb_sel));
        if (e.dmem_req) check("dmem_we", int'(dmem_we), int'(e.dmem_we));
        if (e.dmem_req) check("dmem_be", int'(dmem_be), int'(e.be));
        if (e.alu_chk) check("alu_a_sel", int'(alu_a_sel), int'(e.alu_a));
        if (e.alu_chk) check("alu_b_sel", int'(alu_b_sel), int'(e.alu_b));
      end
    end
  endtask
  task automatic settle();
    @(negedge clk);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    #2;
  endtask
  initial begin
    push_reset(); push_reset();
    n = gen(32'h00500093, 0, 0, 0, 0); run();
    check("addi_cycles", n, 3);
    settle(); check("addi_instret", int'(instret), 1);
    n = gen(32'h00002103, 0, 3, 0, 0); run();
    check("lw_cycles", n, 8);
    settle(); check("lw_instret", int'(instret), 2);
    void'(gen(32'h00000063, 0, 0, 1, 0));
    void'(gen(32'h00000063, 1, 0, 0, 0));
    void'(gen(32'h008000EF, 0, 0, 0, 0));
    void'(gen(32'h000080E7, 0, 0, 0, 0));
    void'(gen(32'h123450B7, 0, 0, 0, 0));
    void'(gen(32'h00001097, 0, 0, 0, 0));
    void'(gen(32'h002081B3, 0, 0, 0, 0));
    void'(gen(32'h00100023, 0, 0, 0, 3));
    void'(gen(32'h00101023, 0, 2, 0, 2));
    void'(gen(32'h00102023, 0, 1, 0, 0));
    void'(gen(32'h00000103, 0, 0, 0, 1));
    void'(gen(32'h00001103, 2, 0, 0, 2));
    for (int i = 0; i < 4; i++) void'(gen(32'h00500093, 0, 0, 0, 0));
    run();
    settle(); check("instret_wrap", int'(instret), 2);
    void'(gen(32'h00102023, 0, 10, 0, 0, 2));
    void'(gen(32'h00500093, 0, 0, 0, 0));
    void'(gen(32'h00101023, 0, 0, 0, 1));
    run();
    check("sh_mis_cause", int'(trap_cause), 3);
    check("sh_mis_instret", int'(instret), 1);
    push_reset();
    n = gen(32'h00500093, 100, 0, 0, 0); run();
    check("fetch_timeout_cycles", n, MT);
    check("fetch_timeout_cause", int'(trap_cause), 1);
    push_reset();
    void'(gen(32'h0000007F, 0, 0, 0, 0)); run();
    check("illegal_cause", int'(trap_cause), 2);
    push_reset();
    void'(gen(32'h00002103, 0, 100, 0, 0)); run();
    check("mem_timeout_cause", int'(trap_cause), 1);
    check("mem_timeout_trap", int'(trap), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
